// File: rtl/sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// sram_req_ctrl : valid/ready front end for a masked single-port SRAM macro,
//                 with optional zero-fill sweep and a 2-entry response skid.
// Revision 1.0
// ============================================================================
module sram_req_ctrl #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 16,
  parameter int MASK_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_pend;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [1:0]        credit;
  logic              fifo_empty;
  logic              fire;
  logic              push;
  logic              pop;

  // Every read in flight (pending in the macro or parked in the FIFO) holds
  // one FIFO slot, so the FIFO can never overflow.
  assign credit     = fifo_cnt + {1'b0, rd_pend};
  assign req_ready  = reset_n && (state == ST_RUN) && (credit < 2'd2);
  assign fire       = req_valid && req_ready;
  assign init_done  = (state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_en     = fire;
    mem_wmode  = req_write;
    mem_addr   = req_addr;
    mem_wmask  = req_wmask;
    mem_wdata  = req_wdata;
    case (state)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = clr_cnt;
        mem_wmask = '1;
        mem_wdata = '0;
        if (clr_cnt == '1) begin
          state_next = ST_RUN;
        end
      end
      default: ;
    endcase
    // Keep the macro idle while reset is held, even though state sits in INIT.
    if (!reset_n) begin
      mem_en = 1'b0;
    end
  end

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign resp_valid = rd_pend || !fifo_empty;
  assign resp_rdata = fifo_empty ? mem_rdata : fifo_mem[rd_ptr];
  assign push       = rd_pend && !(fifo_empty && resp_ready);
  assign pop        = !fifo_empty && resp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rd_pend <= fire && !req_write;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (fifo_cnt == 2'd2)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
`default_nettype none
// Testbench for sram_req_ctrl: behavioural macro, shadow memory and an
// expected-response queue; directed scenarios followed by random traffic.
module tb_sram_req_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [7:0]  req_wmask;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic        init_done;
  logic        mem_en, mem_wmode;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_wmask;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] macro  [512];
  logic [15:0] shadow [512];
  logic [15:0] exp_q  [$];
  logic        fire_s;

  sram_req_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .mem_en     (mem_en),
    .mem_wmode  (mem_wmode),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] apply_mask(input logic [15:0] old, input logic [15:0] d,
                                             input logic [7:0] m);
    logic [15:0] r = old;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[2*i +: 2] = d[2*i +: 2];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Macro model: 1-cycle read latency, garbage on rdata when not reading.
  initial begin
    for (int i = 0; i < 512; i++) macro[i] = 16'($urandom);
  end

  always @(posedge clock) begin
    if (mem_en && mem_wmode) macro[mem_addr] <= apply_mask(macro[mem_addr], mem_wdata, mem_wmask);
    if (mem_en && !mem_wmode) mem_rdata <= macro[mem_addr];
    else                      mem_rdata <= 16'($urandom);
  end

  // Reference model: sampled mid-cycle, updated for the events of the coming edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_outs", {req_ready, resp_valid, mem_en, init_done}, 4'b0000);
      exp_q.delete();
      cyc = 0;
    end else begin
      chk("init_done", init_done, cyc >= 512);
      if (cyc < 512) begin
        chk("init_ready", req_ready, 1'b0);
        chk("init_mem", {mem_en, mem_wmode, mem_wmask, mem_wdata, mem_addr},
            {1'b1, 1'b1, 8'hFF, 16'h0000, 9'(cyc)});
        if (cyc == 511) begin
          for (int i = 0; i < 512; i++) shadow[i] = 16'h0000;
        end
      end else begin
        chk("req_ready", req_ready, exp_q.size() < 2);
        fire_s = req_valid && req_ready;
        chk("mem_en", mem_en, fire_s);
        chk("mem_pass", {mem_wmode, mem_addr, mem_wmask, mem_wdata},
            {req_write, req_addr, req_wmask, req_wdata});
        chk("resp_valid", resp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("resp_rdata", resp_rdata, exp_q[0]);
          if (resp_ready) void'(exp_q.pop_front());
        end
        if (fire_s) begin
          if (req_write) shadow[req_addr] = apply_mask(shadow[req_addr], req_wdata, req_wmask);
          else           exp_q.push_back(shadow[req_addr]);
        end
      end
      cyc++;
    end
  end

  task automatic drv(input logic v, input logic w, input logic [8:0] a, input logic [7:0] m,
                     input logic [15:0] d, input logic rr);
    @(posedge clock);
    #1;
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wmask  = m;
    req_wdata  = d;
    resp_ready = rr;
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) drv(1'b0, 1'b0, 9'h0, 8'h0, 16'h0, rr);
  endtask

  // Holds a request until it is accepted, bounded to 16 cycles.
  task automatic req(input logic w, input logic [8:0] a, input logic [7:0] m,
                     input logic [15:0] d, input logic rr);
    logic done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      drv(1'b1, w, a, m, d, rr);
      @(negedge clock);
      done = req_ready;
    end
    chk("req_accept", done, 1'b1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wmask  = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(514, 1'b1);

    req(1'b1, 9'd5, 8'hFF, 16'hA5C3, 1'b1);
    req(1'b0, 9'd5, 8'h00, 16'h0000, 1'b1);
    idle(2, 1'b1);
    req(1'b0, 9'h1FF, 8'h00, 16'h0000, 1'b1);
    req(1'b1, 9'd9, 8'hFF, 16'hFFFF, 1'b1);
    req(1'b1, 9'd9, 8'h0F, 16'h0000, 1'b1);
    req(1'b0, 9'd9, 8'h00, 16'h0000, 1'b1);
    idle(2, 1'b1);

    // Backpressure: third read must be held off until the consumer drains.
    req(1'b0, 9'd1, 8'h00, 16'h0000, 1'b0);
    req(1'b0, 9'd2, 8'h00, 16'h0000, 1'b0);
    repeat (3) drv(1'b1, 1'b0, 9'd3, 8'h00, 16'h0000, 1'b0);
    req(1'b0, 9'd3, 8'h00, 16'h0000, 1'b1);
    idle(4, 1'b1);

    // Read-then-write hazard on the same address.
    req(1'b1, 9'd7, 8'hFF, 16'h1234, 1'b1);
    idle(1, 1'b1);
    req(1'b0, 9'd7, 8'h00, 16'h0000, 1'b1);
    req(1'b1, 9'd7, 8'hFF, 16'h5678, 1'b1);
    req(1'b0, 9'd7, 8'h00, 16'h0000, 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      drv(($urandom % 4) != 0, ($urandom % 2) != 0,
          (($urandom % 8) == 0) ? 9'h1FF : 9'($urandom % 8),
          8'($urandom), 16'($urandom), ($urandom % 3) != 0);
    end
    idle(4, 1'b1);

    // Reset with one FIFO entry held and a read pending.
    req(1'b0, 9'd3, 8'h00, 16'h0000, 1'b0);
    req(1'b0, 9'd4, 8'h00, 16'h0000, 1'b0);
    drv(1'b0, 1'b0, 9'h0, 8'h00, 16'h0000, 1'b0);
    #2;
    chk("pre_rst_valid", resp_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(514, 1'b1);
    req(1'b0, 9'd5, 8'h00, 16'h0000, 1'b1);
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request/response front end for a 512x16 single-port masked SRAM macro (2-bit mask granularity, 8 mask bits, 1-cycle read latency).
- Converts a valid/ready request stream (reads and masked writes) into macro port cycles.
- Returns read data in request order over a valid/ready response stream, with a 2-entry skid FIFO that absorbs backpressure.
- Optionally zero-fills the whole array after reset before accepting traffic.

Parameters:
- ADDR_W, 9, address width; depth is 2^ADDR_W = 512.
- DATA_W, 16, data width.
- MASK_W, 8, write-mask bits; each bit covers DATA_W/MASK_W = 2 data bits.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  single clock; every flop is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready (fire).
- req_write  in  1  1 = masked write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wmask  in  MASK_W  write mask; bit i enables data bits [2i+1:2i].
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data present.
- resp_ready  in  1  consumer accepts read data.
- resp_rdata  out  DATA_W  read data.
- init_done  out  1  high once in RUN.
- mem_en  out  1  macro enable.
- mem_wmode  out  1  macro write mode.
- mem_addr  out  ADDR_W  macro address.
- mem_wmask  out  MASK_W  macro write mask.
- mem_wdata  out  DATA_W  macro write data.
- mem_rdata  in  DATA_W  macro read data; valid the cycle after a read enable, undefined otherwise.

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, mem_en=0.
  - init_done=0 if CLEAR_ON_RESET, else 1.
  - FIFO empty, rd_pend=0, clear counter=0.
  - State = INIT if CLEAR_ON_RESET, else RUN.
- State INIT:
  - Every cycle: mem_en=1, mem_wmode=1, mem_wmask=all ones, mem_wdata=0, mem_addr=clear counter.
  - Counter increments each cycle.
  - After address 511 is written, go to RUN. INIT lasts exactly 512 cycles.
  - req_ready=0 throughout.
- State RUN:
  - init_done=1.
  - credit = fifo_count + rd_pend.
  - req_ready = (credit < 2). req_ready is independent of the request payload.
- Request fire (combinational pass-through, same cycle):
  - mem_en=1, mem_wmode=req_write, mem_addr=req_addr, mem_wmask=req_wmask, mem_wdata=req_wdata.
  - No fire: mem_en=0; other mem_* outputs follow the req_* inputs.
- Read fire at cycle T: rd_pend=1 during T+1, and mem_rdata is captured during T+1.
- Response path in the cycle where rd_pend=1:
  - FIFO empty: bypass. resp_valid=1, resp_rdata=mem_rdata.
    - resp_ready=1: data is consumed and not pushed.
    - resp_ready=0: data is pushed into the FIFO.
  - FIFO non-empty: resp_valid=1, resp_rdata=FIFO head. mem_rdata is pushed.
  - Pop on resp_valid && resp_ready from a non-empty FIFO.
  - Push and pop in the same cycle are legal; the count is unchanged.
- FIFO holds at most 2 entries. The credit rule guarantees no overflow; overflow is an assertion failure.
- Ordering:
  - Responses are returned strictly in read-request order.
  - Writes produce no response.
- Throughput: one read per cycle with resp_ready held high; first data is visible the cycle after fire (latency 1).
- Hazards:
  - Write at T+1 to the address read at T: the response carries the pre-write value.
  - Read fired after a write has completed returns the new data.
  - Two back-to-back writes to the same address apply in order; mask-disabled bit pairs keep their old contents.
- Backpressure: resp_valid and resp_rdata stay stable while resp_ready=0.
- Reset asserted mid-INIT or mid-RUN: FIFO and rd_pend are discarded and the state returns to its reset value. Any in-flight macro access is abandoned.
- Address wrap: the clear counter is ADDR_W bits wide; the terminal count is 2^ADDR_W-1.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> init_done rises after exactly 512 cycles; mem_addr sweeps 0..511 with wdata=0 and wmask=0xFF; a later read of addr 0x1FF returns 0x0000.
- Write addr 5, wdata 0xA5C3, wmask 0xFF, then read addr 5 with resp_ready=1 -> resp_valid on the next cycle with 0xA5C3.
- Write 0xFFFF to addr 9 with wmask 0xFF, then 0x0000 with wmask 0x0F, then read addr 9 -> 0xFF00.
- Reads of addrs 1,2,3 issued back-to-back with resp_ready=0 -> req_ready drops after 2 accepts.
- Continuation of the previous scenario: raise resp_ready -> data for addrs 1,2,3 returns in order with no loss, and resp_rdata is stable while stalled.
- Read addr 7 (holding 0x1234) at T, write 0x5678 to addr 7 at T+1 -> response is 0x1234; a following read returns 0x5678.
- Assert reset_n=0 with one FIFO entry held and rd_pend=1 -> resp_valid=0 immediately; after release, INIT restarts at addr 0.
